// File: rtl/fdse_ce_seq.sv
// fdse_ce_seq
//   Control sequencer for a bank of falling-edge, sync-set, clock-enabled
//   flip-flops (FDSE_1). On the rising edge of C it produces the CE strobe,
//   the sync-set strobe and the serial D pattern. Those signals are therefore
//   stable half a cycle before the downstream cells sample them on the
//   falling edge.
//
// Parameters
//   WIDTH    width of the divider count and of DIV
//   PAT_LEN  pattern length in bits (2..32)
//   PATTERN  serial pattern, bit 0 emitted first
//   INIT     reset value of D_OUT (matches the downstream INIT)
//
// Ports
//   C        clock, all state updates on the rising edge
//   CLR      asynchronous active-high reset
//   EN       run enable (level)
//   DIV      CE period minus 1, sampled at start and at each reload
//   SET_REQ  set request, rising-edge qualified
//   CE_OUT   one-cycle clock-enable strobe
//   S_OUT    one-cycle synchronous-set strobe
//   D_OUT    serial pattern data, valid while CE_OUT=1
//   SET_ACK  one-cycle acknowledge of a serviced set
//   BUSY     registered (state != IDLE) | pending
//
// Build option
//   FDSE_CE_SEQ_GSR_EN  when defined, glbl.GSR (tri0) resets the block
//                       exactly as CLR does. When undefined, only CLR
//                       resets and glbl is not referenced.

module fdse_ce_seq #(
  parameter int unsigned        WIDTH   = 8,
  parameter int unsigned        PAT_LEN = 16,
  parameter logic [PAT_LEN-1:0] PATTERN = 16'hA5C3,
  parameter logic               INIT    = 1'b1
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV,
  input  logic             SET_REQ,
  output logic             CE_OUT,
  output logic             S_OUT,
  output logic             D_OUT,
  output logic             SET_ACK,
  output logic             BUSY
);

  localparam int unsigned   PW       = $clog2(PAT_LEN);
  localparam logic [PW-1:0] PTR_LAST = PW'(PAT_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] count;
  logic [PW-1:0]    ptr;
  logic             pending;
  logic             req_d;

  // Combined reset source
  logic rst;
`ifdef FDSE_CE_SEQ_GSR_EN
  tri0 gsr;
  assign gsr = glbl.GSR;
  assign rst = CLR | gsr;
`else
  assign rst = CLR;
`endif

  // Helper terms for the sequencer
  logic          set_edge;
  logic          slot;
  logic          take_set;
  logic [PW-1:0] ptr_next;

  always_comb begin
    set_edge = SET_REQ & ~req_d;
    slot     = (count == '0);
    // A request edge that lands on the slot cycle is taken at that slot.
    take_set = pending | set_edge;
    ptr_next = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
  end

  always_ff @(posedge C or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      ptr     <= '0;
      pending <= 1'b0;
      req_d   <= 1'b0;
      CE_OUT  <= 1'b0;
      S_OUT   <= 1'b0;
      SET_ACK <= 1'b0;
      BUSY    <= 1'b0;
      D_OUT   <= INIT;
    end else begin
      req_d   <= SET_REQ;
      CE_OUT  <= 1'b0;
      S_OUT   <= 1'b0;
      SET_ACK <= 1'b0;
      // BUSY reflects the state and pending flag of the previous cycle, so
      // it stays high through the SET_ACK cycle.
      BUSY    <= (state != IDLE) | pending;
      // Latch new request edges. An edge while already pending is absorbed.
      pending <= pending | set_edge;

      case (state)
        IDLE: begin
          if (pending) begin
            // A set requested while idle is serviced without a CE.
            S_OUT   <= 1'b1;
            pending <= 1'b0;
            count   <= DIV;
            state   <= ACK;
          end else if (EN) begin
            count <= DIV;
            state <= RUN;
          end
        end

        RUN: begin
          if (!EN) begin
            // Drop out without a CE. ptr and pending survive, so the
            // pattern resumes at the same bit on the next RUN.
            state <= IDLE;
          end else if (slot) begin
            CE_OUT <= 1'b1;
            count  <= DIV;
            if (take_set) begin
              // The set consumes this slot. D_OUT is held and ptr stays.
              S_OUT   <= 1'b1;
              pending <= 1'b0;
              state   <= ACK;
            end else begin
              D_OUT <= PATTERN[ptr];
              ptr   <= ptr_next;
            end
          end else begin
            count <= count - 1'b1;
          end
        end

        ACK: begin
          SET_ACK <= 1'b1;
          if (EN) begin
            // The counter keeps running so the CE cadence is unbroken.
            // A slot here fires a normal CE.
            state <= RUN;
            if (slot) begin
              CE_OUT <= 1'b1;
              D_OUT  <= PATTERN[ptr];
              ptr    <= ptr_next;
              count  <= DIV;
            end else begin
              count <= count - 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fdse_ce_seq.sv
// tb_fdse_ce_seq
//   Directed self-checking bench for fdse_ce_seq. Per-cycle vectors hold
//   {EN, DIV, SET_REQ} and the expected {CE_OUT, S_OUT, D_OUT, SET_ACK, BUSY}
//   one cycle later. Hand-written sequences cover reset, the full pattern
//   walk and a CLR that aborts a pending set.

module tb_fdse_ce_seq;

  logic       C = 1'b0;
  logic       CLR;
  logic       EN;
  logic [7:0] DIV;
  logic       SET_REQ;
  logic       CE_OUT;
  logic       S_OUT;
  logic       D_OUT;
  logic       SET_ACK;
  logic       BUSY;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Expected D_OUT at successive CE pulses, first bit on the left.
  logic [0:15] seq_bits = 16'b1100_0011_1010_0101;

  typedef struct {
    logic       en;
    logic [7:0] div;
    logic       req;
    logic [4:0] exp;   // {ce, s, d, ack, busy}
  } vec_t;

  vec_t vecs[$];
  int   seg_a;

  fdse_ce_seq #(
    .WIDTH  (8),
    .PAT_LEN(16),
    .PATTERN(16'hA5C3),
    .INIT   (1'b1)
  ) dut (
    .C      (C),
    .CLR    (CLR),
    .EN     (EN),
    .DIV    (DIV),
    .SET_REQ(SET_REQ),
    .CE_OUT (CE_OUT),
    .S_OUT  (S_OUT),
    .D_OUT  (D_OUT),
    .SET_ACK(SET_ACK),
    .BUSY   (BUSY)
  );

  always #5 C = ~C;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  function automatic void add(input logic en, input logic [7:0] div,
                              input logic req, input logic [4:0] exp);
    vec_t v;
    v.en  = en;
    v.div = div;
    v.req = req;
    v.exp = exp;
    vecs.push_back(v);
  endfunction

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      EN      = vecs[i].en;
      DIV     = vecs[i].div;
      SET_REQ = vecs[i].req;
      tick();
      chk($sformatf("vec%0d.ce", i),   CE_OUT,  vecs[i].exp[4]);
      chk($sformatf("vec%0d.s", i),    S_OUT,   vecs[i].exp[3]);
      chk($sformatf("vec%0d.d", i),    D_OUT,   vecs[i].exp[2]);
      chk($sformatf("vec%0d.ack", i),  SET_ACK, vecs[i].exp[1]);
      chk($sformatf("vec%0d.busy", i), BUSY,    vecs[i].exp[0]);
    end
  endtask

  initial begin
    CLR = 1'b1; EN = 1'b0; DIV = 8'd0; SET_REQ = 1'b0;

    // Segment A: start with DIV=3, covering the first two CEs.
    add(1'b1, 8'd3, 1'b0, 5'b00100);  // IDLE->RUN, count=3
    add(1'b1, 8'd3, 1'b0, 5'b00101);
    add(1'b1, 8'd3, 1'b0, 5'b00101);
    add(1'b1, 8'd3, 1'b0, 5'b00101);
    add(1'b1, 8'd3, 1'b0, 5'b10101);  // CE, bit0=1
    add(1'b1, 8'd3, 1'b0, 5'b00101);
    add(1'b1, 8'd3, 1'b0, 5'b00101);
    add(1'b1, 8'd3, 1'b0, 5'b00101);
    add(1'b1, 8'd3, 1'b0, 5'b10101);  // CE, bit1=1
    seg_a = vecs.size();
    // Segment B begins after the pattern walk. ptr=2, count=3, D=1.
    add(1'b0, 8'd0, 1'b0, 5'b00101);  // EN low -> IDLE, no CE
    add(1'b0, 8'd0, 1'b0, 5'b00100);
    add(1'b1, 8'd0, 1'b0, 5'b00100);  // IDLE->RUN, count=0
    add(1'b1, 8'd0, 1'b0, 5'b10001);  // bit2=0
    add(1'b1, 8'd0, 1'b0, 5'b10001);  // bit3=0
    add(1'b1, 8'd0, 1'b0, 5'b10001);  // bit4=0
    add(1'b1, 8'd0, 1'b0, 5'b10001);  // bit5=0
    add(1'b1, 8'd0, 1'b0, 5'b10101);  // bit6=1
    add(1'b1, 8'd2, 1'b0, 5'b10101);  // bit7=1, reload with DIV=2
    add(1'b1, 8'd2, 1'b0, 5'b00101);
    add(1'b1, 8'd2, 1'b0, 5'b00101);
    add(1'b1, 8'd2, 1'b0, 5'b10101);  // bit8=1
    add(1'b1, 8'd2, 1'b0, 5'b00101);
    add(1'b1, 8'd2, 1'b0, 5'b00101);
    add(1'b1, 8'd2, 1'b0, 5'b10001);  // bit9=0, count=2
    add(1'b1, 8'd4, 1'b1, 5'b00001);  // request edge, pending
    add(1'b1, 8'd4, 1'b1, 5'b00001);
    add(1'b1, 8'd4, 1'b1, 5'b11001);  // slot: S+CE, D held
    add(1'b1, 8'd4, 1'b1, 5'b00011);  // SET_ACK
    add(1'b1, 8'd4, 1'b1, 5'b00001);  // held high: no retrigger
    add(1'b1, 8'd4, 1'b1, 5'b00001);
    add(1'b1, 8'd4, 1'b1, 5'b00001);
    add(1'b1, 8'd4, 1'b1, 5'b10101);  // bit10=1, ptr did not move
    add(1'b1, 8'd4, 1'b0, 5'b00101);
    add(1'b1, 8'd4, 1'b0, 5'b00101);
    add(1'b1, 8'd4, 1'b0, 5'b00101);
    add(1'b1, 8'd4, 1'b0, 5'b00101);
    add(1'b1, 8'd4, 1'b1, 5'b11101);  // edge on slot cycle: set taken
    add(1'b1, 8'd4, 1'b0, 5'b00111);  // SET_ACK
    add(1'b1, 8'd4, 1'b0, 5'b00101);
    add(1'b1, 8'd4, 1'b0, 5'b00101);
    add(1'b1, 8'd4, 1'b0, 5'b00101);
    add(1'b1, 8'd4, 1'b0, 5'b10001);  // bit11=0
    add(1'b1, 8'd4, 1'b0, 5'b00001);
    add(1'b1, 8'd4, 1'b0, 5'b00001);
    add(1'b1, 8'd4, 1'b0, 5'b00001);
    add(1'b1, 8'd4, 1'b0, 5'b00001);
    add(1'b0, 8'd4, 1'b0, 5'b00001);  // EN low on slot: no CE
    add(1'b0, 8'd4, 1'b0, 5'b00000);
    add(1'b1, 8'd0, 1'b0, 5'b00000);  // IDLE->RUN
    add(1'b1, 8'd0, 1'b0, 5'b10001);  // resumes at bit12=0
    add(1'b1, 8'd0, 1'b0, 5'b10101);  // bit13=1
    add(1'b0, 8'd0, 1'b0, 5'b00101);
    add(1'b0, 8'd0, 1'b0, 5'b00100);
    add(1'b0, 8'd0, 1'b1, 5'b00100);  // idle request edge
    add(1'b0, 8'd0, 1'b1, 5'b01101);  // S without CE
    add(1'b0, 8'd0, 1'b1, 5'b00111);  // SET_ACK
    add(1'b0, 8'd0, 1'b0, 5'b00100);  // BUSY drops
    add(1'b0, 8'd0, 1'b0, 5'b00100);

    // Reset state
    repeat (2) @(posedge C);
    #1;
    chk("rst.ce",   CE_OUT,  1'b0);
    chk("rst.s",    S_OUT,   1'b0);
    chk("rst.ack",  SET_ACK, 1'b0);
    chk("rst.busy", BUSY,    1'b0);
    chk("rst.d",    D_OUT,   1'b1);
    @(negedge C);
    CLR = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold.ce",   CE_OUT,  1'b0);
      chk("hold.s",    S_OUT,   1'b0);
      chk("hold.ack",  SET_ACK, 1'b0);
      chk("hold.busy", BUSY,    1'b0);
      chk("hold.d",    D_OUT,   1'b1);
    end

    run_vecs(0, seg_a);

    // Full pattern walk with DIV=3: CEs 3..18, wrapping past bit 15.
    EN = 1'b1; DIV = 8'd3; SET_REQ = 1'b0;
    for (int k = 2; k < 18; k++) begin
      for (int j = 0; j < 3; j++) begin
        tick();
        chk("pat.gap.ce", CE_OUT, 1'b0);
        chk("pat.gap.d",  D_OUT,  seq_bits[(k - 1) % 16]);
      end
      tick();
      chk($sformatf("pat%0d.ce", k), CE_OUT, 1'b1);
      chk($sformatf("pat%0d.d", k),  D_OUT,  seq_bits[k % 16]);
    end

    run_vecs(seg_a, vecs.size());

    // CLR while a set is pending: the set is dropped.
    EN = 1'b1; DIV = 8'd4; SET_REQ = 1'b0;
    tick();
    SET_REQ = 1'b1;
    tick();
    chk("clr.pre.busy", BUSY, 1'b1);
    #2 CLR = 1'b1;
    #1;
    chk("clr.ce",   CE_OUT,  1'b0);
    chk("clr.s",    S_OUT,   1'b0);
    chk("clr.ack",  SET_ACK, 1'b0);
    chk("clr.busy", BUSY,    1'b0);
    chk("clr.d",    D_OUT,   1'b1);
    SET_REQ = 1'b0;
    EN      = 1'b0;
    @(negedge C);
    CLR = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("post.ce",   CE_OUT,  1'b0);
      chk("post.s",    S_OUT,   1'b0);
      chk("post.ack",  SET_ACK, 1'b0);
      chk("post.busy", BUSY,    1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
